// File: rtl/multicycle_alu.sv
// multicycle_alu: iterative ALU with saturating add/sub, packed-lane add, lane reduction and bit-serial shifts
module multicycle_alu #(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     ovfl,
    output logic                     illegal
);
    localparam int NL = WIDTH / LANE_W;
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_LANE = SW'(NL - 1);
    localparam logic [2:0] OP_RED = 3'b011;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state;
    logic [2:0]        op_r;
    logic [WIDTH-1:0]  a_r, b_r, acc;
    logic [SW-1:0]     cnt;
    logic [WIDTH:0]    full;
    logic              add_ovf, is_shift, last, exec_ovf;
    logic [WIDTH-1:0]  add_res, padd_res, sh_next, red_next, exec_res;
    logic [NL-1:0]     lane_ovf;
    logic [LANE_W-1:0] la, lb;

    generate
        for (genvar g = 0; g < NL; g++) begin : g_lane
            logic [LANE_W:0] s;
            assign s = {a_r[g*LANE_W+LANE_W-1], a_r[g*LANE_W +: LANE_W]}
                     + {b_r[g*LANE_W+LANE_W-1], b_r[g*LANE_W +: LANE_W]};
            assign lane_ovf[g] = s[LANE_W] ^ s[LANE_W-1];
            assign padd_res[g*LANE_W +: LANE_W] = lane_ovf[g] ? {s[LANE_W], {(LANE_W-1){~s[LANE_W]}}} : s[LANE_W-1:0];
        end
    endgenerate

    always_comb begin
        full = op_r[0] ? {a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r} : {a_r[WIDTH-1], a_r} + {b_r[WIDTH-1], b_r};
        add_ovf = full[WIDTH] ^ full[WIDTH-1];
        add_res = add_ovf ? {full[WIDTH], {(WIDTH-1){~full[WIDTH]}}} : full[WIDTH-1:0];
        // cnt doubles as the lane index while reducing
        la = LANE_W'(a_r >> (cnt * LANE_W));
        lb = LANE_W'(b_r >> (cnt * LANE_W));
        red_next = acc + {{(WIDTH-LANE_W){la[LANE_W-1]}}, la} + {{(WIDTH-LANE_W){lb[LANE_W-1]}}, lb};
        is_shift = op_r[2] && op_r != OP_ILL;
        sh_next = ~|cnt ? a_r :
                  op_r[1:0] == 2'b00 ? {a_r[WIDTH-2:0], 1'b0} :
                  op_r[1:0] == 2'b01 ? {a_r[WIDTH-1], a_r[WIDTH-1:1]} :
                                       {a_r[0], a_r[WIDTH-1:1]};
        last = is_shift ? cnt < SW'(2) : op_r == OP_RED ? cnt == LAST_LANE : 1'b1;
        exec_res = op_r == OP_ILL ? '0 : is_shift ? sh_next : op_r == OP_RED ? red_next : op_r[1] ? padd_res : add_res;
        exec_ovf = op_r[2] || op_r == OP_RED ? 1'b0 : op_r[1] ? |lane_ovf : add_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ovfl      <= 1'b0;
            illegal   <= 1'b0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r     <= op;
                    a_r      <= a;
                    b_r      <= b;
                    acc      <= '0;
                    cnt      <= op == OP_RED ? '0 : shamt;
                    in_ready <= 1'b0;
                    state    <= EXEC;
                end
                EXEC: begin
                    if (is_shift) begin
                        a_r <= sh_next;
                        cnt <= cnt - 1'b1;
                    end
                    if (op_r == OP_RED) begin
                        acc <= red_next;
                        cnt <= cnt + 1'b1;
                    end
                    if (last) begin
                        result    <= exec_res;
                        ovfl      <= exec_ovf;
                        illegal   <= op_r == OP_ILL;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
